// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: FILL, WASH, RINSE passes, SPIN and an
// optional extra spin, paced by a 1 s tick, with lid pause/resume and cancel.
module wash_sequencer #(
    parameter int unsigned TICK_DIV  = 18000000,
    parameter int unsigned DW_SMALL  = 3,
    parameter int unsigned DW_MEDIUM = 5,
    parameter int unsigned DW_LARGE  = 8,
    parameter int unsigned MAX_RINSE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] load_sel,
    input  logic [1:0] temp_sel,
    input  logic [1:0] rinse_num,
    input  logic       extra_spin,
    input  logic       lid_open,
    input  logic       start,
    input  logic       cancel,
    output logic [2:0] state,
    output logic [5:0] remaining,
    output logic [1:0] rinse_idx,
    output logic       paused,
    output logic       done,
    output logic       err,
    output logic       valve_hot,
    output logic       valve_cold,
    output logic       motor
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_RINSE = 3'd3;
    localparam logic [2:0] S_SPIN  = 3'd4;
    localparam logic [2:0] S_XSPIN = 3'd5;
    localparam logic [2:0] S_PAUSE = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [2:0]       saved_q, saved_d;
    logic [5:0]       remaining_q, remaining_d;
    logic [1:0]       ridx_q, ridx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             start_q;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             paused_q, paused_d;
    logic [5:0]       dwell_q, dwell_d;
    logic [1:0]       temp_q, temp_d;
    logic [1:0]       rtot_q, rtot_d;
    logic             xspin_q, xspin_d;

    logic             start_edge;
    logic             timed;
    logic             tick;
    logic             settings_ok;
    logic [5:0]       dwell_sel;
    logic [1:0]       rinse_req;

    assign start_edge  = start & ~start_q;
    assign timed       = (state_q >= S_FILL) && (state_q <= S_XSPIN);
    assign tick        = timed && (div_q == DIV_W'(TICK_DIV - 1));
    assign settings_ok = !lid_open && (load_sel != 2'b11) && (temp_sel != 2'b11);

    // Dwell per load size; invalid load never gets latched.
    always_comb begin
        case (load_sel)
            2'b00:   dwell_sel = 6'(DW_SMALL);
            2'b01:   dwell_sel = 6'(DW_MEDIUM);
            2'b10:   dwell_sel = 6'(DW_LARGE);
            default: dwell_sel = 6'd0;
        endcase
    end

    // Requested rinse count: zero means one pass, clamp to the maximum.
    assign rinse_req = (rinse_num == 2'd0) ? 2'd1 :
                       (32'(rinse_num) > MAX_RINSE) ? 2'(MAX_RINSE) : rinse_num;

    // State and datapath registers; start_q resets high so a held start is no edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            saved_q     <= S_IDLE;
            remaining_q <= 6'd0;
            ridx_q      <= 2'd0;
            div_q       <= '0;
            start_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            paused_q    <= 1'b0;
            dwell_q     <= 6'd0;
            temp_q      <= 2'd0;
            rtot_q      <= 2'd0;
            xspin_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            remaining_q <= remaining_d;
            ridx_q      <= ridx_d;
            div_q       <= div_d;
            start_q     <= start;
            done_q      <= done_d;
            err_q       <= err_d;
            paused_q    <= paused_d;
            dwell_q     <= dwell_d;
            temp_q      <= temp_d;
            rtot_q      <= rtot_d;
            xspin_q     <= xspin_d;
        end
    end

    // Next-state logic: cancel beats lid_open beats tick.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        remaining_d = remaining_q;
        ridx_d      = ridx_q;
        div_d       = div_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dwell_d     = dwell_q;
        temp_d      = temp_q;
        rtot_d      = rtot_q;
        xspin_d     = xspin_q;

        case (state_q)
            S_IDLE: begin
                remaining_d = 6'd0;
                ridx_d      = 2'd0;
                div_d       = '0;
                if (start_edge) begin
                    if (!settings_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_FILL;
                        remaining_d = dwell_sel;
                        dwell_d     = dwell_sel;
                        temp_d      = temp_sel;
                        rtot_d      = rinse_req;
                        xspin_d     = extra_spin;
                    end
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN, S_XSPIN: begin
                if (cancel) begin
                    state_d     = S_IDLE;
                    remaining_d = 6'd0;
                    ridx_d      = 2'd0;
                    div_d       = '0;
                end else if (lid_open) begin
                    state_d = S_PAUSE;
                    saved_d = state_q;
                end else if (tick) begin
                    div_d = '0;
                    if (remaining_q == 6'd1) begin
                        remaining_d = dwell_q;
                        case (state_q)
                            S_FILL: state_d = S_WASH;
                            S_WASH: begin
                                state_d = S_RINSE;
                                ridx_d  = 2'd1;
                            end
                            S_RINSE: begin
                                if (ridx_q < rtot_q) begin
                                    ridx_d = ridx_q + 2'd1;
                                end else begin
                                    state_d = S_SPIN;
                                    ridx_d  = 2'd0;
                                end
                            end
                            S_SPIN: begin
                                if (xspin_q) begin
                                    state_d = S_XSPIN;
                                end else begin
                                    state_d     = S_IDLE;
                                    remaining_d = 6'd0;
                                    done_d      = 1'b1;
                                end
                            end
                            default: begin
                                state_d     = S_IDLE;
                                remaining_d = 6'd0;
                                done_d      = 1'b1;
                            end
                        endcase
                    end else begin
                        remaining_d = remaining_q - 6'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_PAUSE: begin
                if (cancel) begin
                    state_d     = S_IDLE;
                    remaining_d = 6'd0;
                    ridx_d      = 2'd0;
                    div_d       = '0;
                end else if (!lid_open && start_edge) begin
                    state_d = saved_q;
                    div_d   = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = 6'd0;
                ridx_d      = 2'd0;
                div_d       = '0;
            end
        endcase

        paused_d = (state_d == S_PAUSE);
    end

    assign state     = state_q;
    assign remaining = remaining_q;
    assign rinse_idx = ridx_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign err       = err_q;

    // Actuators decode directly from the current state and latched temperature.
    assign valve_hot  = (state_q == S_FILL) && ((temp_q == 2'b00) || (temp_q == 2'b01));
    assign valve_cold = ((state_q == S_FILL) && ((temp_q == 2'b01) || (temp_q == 2'b10)))
                        || (state_q == S_RINSE);
    assign motor      = (state_q == S_WASH) || (state_q == S_RINSE)
                        || (state_q == S_SPIN) || (state_q == S_XSPIN);

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with a 4-clock tick.
module tb_wash_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] load_sel = 2'd0;
    logic [1:0] temp_sel = 2'd0;
    logic [1:0] rinse_num = 2'd0;
    logic       extra_spin = 1'b0;
    logic       lid_open = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] state;
    logic [5:0] remaining;
    logic [1:0] rinse_idx;
    logic       paused, done, err, valve_hot, valve_cold, motor;

    wash_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .load_sel(load_sel), .temp_sel(temp_sel),
        .rinse_num(rinse_num), .extra_spin(extra_spin), .lid_open(lid_open),
        .start(start), .cancel(cancel), .state(state), .remaining(remaining),
        .rinse_idx(rinse_idx), .paused(paused), .done(done), .err(err),
        .valve_hot(valve_hot), .valve_cold(valve_cold), .motor(motor)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {state, remaining, rinse_idx, paused, done, err, valve_hot, valve_cold, motor};

    int total = 0;
    int bad = 0;

    typedef struct { int st; int rem; int ridx; } obs_t;
    obs_t q[$];

    typedef struct {
        logic [1:0] load; logic [1:0] temp; logic lid;
        logic exp_err; int exp_state; int exp_rem;
    } vec_t;
    vec_t tbl[8];

    // Expected output word from the specification's rules.
    function automatic logic [16:0] ev(input int st, input int rem, input int ridx,
                                       input bit dn, input bit er, input int tmp);
        logic vh, vc, mo, pa;
        pa = (st == 6);
        vh = (st == 1) && (tmp == 0 || tmp == 1);
        vc = ((st == 1) && (tmp == 1 || tmp == 2)) || (st == 3);
        mo = (st >= 2) && (st <= 5);
        return {3'(st), 6'(rem), 2'(ridx), pa, dn, er, vh, vc, mo};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got st/rem/ri/p/d/e/h/c/m=%0d/%0d/%0d/%b/%b/%b/%b/%b/%b want=%0d/%0d/%0d/%b/%b/%b/%b/%b/%b",
                     name, act[16:14], act[13:8], act[7:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[16:14], exp[13:8], exp[7:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dwell_of(input int load);
        return (load == 0) ? 3 : (load == 1) ? 5 : 8;
    endfunction

    task automatic add_phase(input int st, input int d, input int ridx);
        obs_t o;
        for (int s = d; s >= 1; s--) begin
            for (int k = 0; k < TD; k++) begin
                o.st = st; o.rem = s; o.ridx = ridx;
                q.push_back(o);
            end
        end
    endtask

    // Per-cycle expected trace of a whole program: every second lasts TD clocks.
    task automatic build(input int load, input int rinse, input int xs);
        int d, rt;
        q.delete();
        d  = dwell_of(load);
        rt = (rinse == 0) ? 1 : ((rinse > 3) ? 3 : rinse);
        add_phase(1, d, 0);
        add_phase(2, d, 0);
        for (int r = 1; r <= rt; r++) add_phase(3, d, r);
        add_phase(4, d, 0);
        if (xs != 0) add_phase(5, d, 0);
    endtask

    // Runs one program from IDLE, optionally pausing, cancelling or resetting at a trace index.
    task automatic run_program(input string name, input int load, input int temp, input int rinse,
                               input int xs, input int pause_at, input int cancel_at,
                               input int reset_at, input bit scramble);
        int  i;
        int  guard;
        bit  did_pause;
        build(load, rinse, xs);
        load_sel = 2'(load); temp_sel = 2'(temp); rinse_num = 2'(rinse); extra_spin = xs[0];
        lid_open = 1'b0; cancel = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        i = 0; guard = 0; did_pause = 1'b0;
        while (i < q.size()) begin
            guard++;
            if (guard > 4000) begin
                total++; bad++;
                $display("FAIL %s: cycle budget expired", name);
                return;
            end
            check(name, ev(q[i].st, q[i].rem, q[i].ridx, 1'b0, 1'b0, temp));
            if (scramble) begin
                load_sel = 2'($urandom); temp_sel = 2'($urandom);
                rinse_num = 2'($urandom); extra_spin = 1'($urandom);
            end
            if (i == cancel_at) begin
                cancel = 1'b1;
                step();
                cancel = 1'b0;
                check({name, "_cancel"}, ev(0, 0, 0, 1'b0, 1'b0, temp));
                step();
                check({name, "_nodone"}, ev(0, 0, 0, 1'b0, 1'b0, temp));
                return;
            end
            if (i == reset_at) begin
                #2;
                rst_n = 1'b1;
                start = 1'b1;
                #1;
                check({name, "_rst_async"}, ev(0, 0, 0, 1'b0, 1'b0, 0));
                step();
                step();
                @(negedge clk);
                rst_n = 1'b0;
                step();
                check({name, "_held_start"}, ev(0, 0, 0, 1'b0, 1'b0, 0));
                start = 1'b0;
                step();
                check({name, "_post_rst"}, ev(0, 0, 0, 1'b0, 1'b0, 0));
                return;
            end
            if (i == pause_at && !did_pause) begin
                lid_open = 1'b1;
                step();
                check({name, "_pause"}, ev(6, q[i].rem, q[i].ridx, 1'b0, 1'b0, temp));
                step();
                check({name, "_pause_hold"}, ev(6, q[i].rem, q[i].ridx, 1'b0, 1'b0, temp));
                start = 1'b1;
                step();
                check({name, "_pause_lidstart"}, ev(6, q[i].rem, q[i].ridx, 1'b0, 1'b0, temp));
                start = 1'b0;
                lid_open = 1'b0;
                step();
                check({name, "_pause_closed"}, ev(6, q[i].rem, q[i].ridx, 1'b0, 1'b0, temp));
                start = 1'b1;
                step();
                start = 1'b0;
                i = i - (i % TD);
                did_pause = 1'b1;
                continue;
            end
            step();
            i++;
        end
        check({name, "_done"}, ev(0, 0, 0, 1'b1, 1'b0, temp));
        step();
        check({name, "_done_end"}, ev(0, 0, 0, 1'b0, 1'b0, temp));
    endtask

    initial begin
        tbl[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1, 3};
        tbl[1] = '{2'b11, 2'b00, 1'b0, 1'b1, 0, 0};
        tbl[2] = '{2'b00, 2'b11, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{2'b01, 2'b01, 1'b1, 1'b1, 0, 0};
        tbl[4] = '{2'b10, 2'b10, 1'b0, 1'b0, 1, 8};
        tbl[5] = '{2'b01, 2'b01, 1'b0, 1'b0, 1, 5};
        tbl[6] = '{2'b11, 2'b11, 1'b0, 1'b1, 0, 0};
        tbl[7] = '{2'b00, 2'b00, 1'b1, 1'b1, 0, 0};

        step(); step();
        check("reset_state", ev(0, 0, 0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        step();
        check("after_release", ev(0, 0, 0, 1'b0, 1'b0, 0));

        // Start acceptance / rejection table.
        for (int n = 0; n < 8; n++) begin
            load_sel = tbl[n].load; temp_sel = tbl[n].temp; lid_open = tbl[n].lid;
            rinse_num = 2'd1; start = 1'b1;
            step();
            start = 1'b0;
            check($sformatf("tbl%0d_start", n),
                  ev(tbl[n].exp_state, tbl[n].exp_rem, 0, 1'b0, tbl[n].exp_err, int'(tbl[n].temp)));
            lid_open = 1'b0;
            if (tbl[n].exp_state != 0) cancel = 1'b1;
            step();
            cancel = 1'b0;
            check($sformatf("tbl%0d_idle", n), ev(0, 0, 0, 1'b0, 1'b0, 0));
        end

        run_program("basic",      0, 0, 1, 0, -1, -1, -1, 1'b0);
        run_program("three_rinse", 1, 1, 3, 1, -1, -1, -1, 1'b1);
        run_program("lid_wash",   0, 2, 1, 0, 17, -1, -1, 1'b0);
        run_program("rinse_zero", 2, 2, 0, 0, -1, -1, -1, 1'b0);
        run_program("cancel_r2",  0, 0, 3, 0, -1, 40, -1, 1'b0);
        run_program("reset_spin", 0, 1, 1, 0, -1, -1, 40, 1'b0);
        run_program("after_reset", 0, 0, 1, 1, -1, -1, -1, 1'b0);

        // Randomized programs against the trace model.
        for (int n = 0; n < 12; n++) begin
            int ld, tp, rn, xs, pa, ca;
            bit lid;
            ld = $urandom_range(0, 3); tp = $urandom_range(0, 3);
            rn = $urandom_range(0, 3); xs = $urandom_range(0, 1);
            lid = ($urandom_range(0, 5) == 0);
            if (ld == 3 || tp == 3 || lid) begin
                load_sel = 2'(ld); temp_sel = 2'(tp); lid_open = lid; start = 1'b1;
                step();
                start = 1'b0;
                check($sformatf("rnd%0d_reject", n), ev(0, 0, 0, 1'b0, 1'b1, 0));
                lid_open = 1'b0;
                step();
                check($sformatf("rnd%0d_reject_end", n), ev(0, 0, 0, 1'b0, 1'b0, 0));
            end else begin
                build(ld, rn, xs);
                pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, q.size() - 1)) : -1;
                ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
                if (ca == pa) ca = -1;
                run_program($sformatf("rnd%0d", n), ld, tp, rn, xs, pa, ca, -1, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TICK_DIV, 18000000, clk cycles per 1 s tick.
- DW_SMALL, 3, phase dwell (s) for load 00.
- DW_MEDIUM, 5, phase dwell (s) for load 01.
- DW_LARGE, 8, phase dwell (s) for load 10; all DW_* within 1..63.
- MAX_RINSE, 3, maximum rinse passes, 1..3.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- load_sel  in  2  00 small, 01 medium, 10 large, 11 invalid.
- temp_sel  in  2  00 hot, 01 warm, 10 cold, 11 invalid.
- rinse_num  in  2  requested rinse passes; 0 treated as 1; values above MAX_RINSE clamp to MAX_RINSE.
- extra_spin  in  1  add XSPIN phase.
- lid_open  in  1  1 = lid open.
- start  in  1  level input; only the rising edge (registered compare) acts.
- cancel  in  1  abort to IDLE.
- state  out  3  current state code.
- remaining  out  6  seconds left in current phase.
- rinse_idx  out  2  current rinse pass (1-based); 0 outside RINSE.
- paused  out  1  high in PAUSE.
- done  out  1  1-cycle pulse on normal cycle completion.
- err  out  1  1-cycle pulse on rejected start.
- valve_hot, valve_cold, motor  out  1 each  actuator drives.

Function
REQ-003 Internal divider produces a 1-cycle tick every TICK_DIV clks; the divider clears on start acceptance and on PAUSE exit, so the first second is always full length.
REQ-004 State codes: IDLE 0, FILL 1, WASH 2, RINSE 3, SPIN 4, XSPIN 5, PAUSE 6; code 7 is unreachable and returns to IDLE next cycle.
REQ-005 IDLE + start edge + lid closed + valid load + valid temp -> FILL next cycle; dwell, temp, rinse total and extra_spin are latched at this point; later switch changes are ignored until the next IDLE.
REQ-006 IDLE + start edge with any invalid condition (lid open, load 11, temp 11) -> err pulse, state stays IDLE.
REQ-007 On entry to each timed phase, remaining loads latched dwell; each tick decrements it; a tick with remaining==1 ends the phase, so each phase lasts exactly dwell ticks.
REQ-008 Sequence: FILL->WASH->RINSE; RINSE end: if rinse_idx < rinse total, re-enter RINSE with rinse_idx+1 and remaining reloaded, else SPIN; SPIN end -> XSPIN if latched extra_spin, else IDLE; XSPIN end -> IDLE.
REQ-009 done pulses exactly one cycle on a SPIN/XSPIN->IDLE transition; it does not pulse on cancel.
REQ-010 lid_open in any timed phase -> PAUSE next cycle; the phase, remaining and rinse_idx are saved and frozen; all actuators are off.
REQ-011 PAUSE + lid closed + start edge -> return to the saved phase with the saved remaining; a start edge with the lid still open has no effect and raises no err.
REQ-012 cancel in any non-IDLE state (including PAUSE) -> IDLE next cycle, remaining=0, rinse_idx=0.
REQ-013 Priority within one cycle: cancel > lid_open > tick; a tick coinciding with lid_open is discarded.
REQ-014 Actuators are combinational from state and latched temp:
- valve_hot = FILL and temp hot/warm.
- valve_cold = (FILL and temp warm/cold) or RINSE.
- motor = WASH, RINSE, SPIN or XSPIN.
REQ-015 In IDLE, remaining=0 and rinse_idx=0.

Reset
REQ-016 rst_n=1 forces immediately: state IDLE, divider 0, remaining 0, rinse_idx 0, done/err/paused 0, all actuators 0, latched settings cleared; this applies mid-cycle, including from PAUSE.
REQ-017 A start held high through reset release is not taken as an edge.

Verification (TICK_DIV=4)
REQ-018 load 00, temp 00, rinse_num 1, extra_spin 0, start -> FILL/WASH/RINSE/SPIN each exactly 12 clks, remaining 3,2,1 per phase; done pulse; IDLE.
REQ-019 load 01, rinse_num 3, extra_spin 1 -> RINSE runs 3 times with rinse_idx 1,2,3, then SPIN, XSPIN (5 s each), then done.
REQ-020 lid opens in WASH with remaining=2 -> PAUSE, motor 0, remaining held 2; lid closes and start edge -> WASH resumes, 8 clks to RINSE.
REQ-021 start with load 11, or temp 11, or lid open -> err 1 clk, state stays 0; rinse_num 0 runs one rinse.
REQ-022 cancel in RINSE pass 2 -> IDLE next clk, no done pulse; rst_n asserted during SPIN -> all outputs at reset values the same cycle.
